// File: rtl/ir_sample_seq.sv
// IR sensor sampling sequencer: periodic emitter enable, settle, 8-channel A2D sweep, atomic bank commit.
// Optional build macro IR_INV_EN stores each result inverted ((2^RES_W-1) - res) so darker reads larger.
module ir_sample_seq #(
    parameter int PERIOD = 4096,
    parameter int SETTLE = 1024,
    parameter int RES_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    input  logic [2:0]       sel,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    output logic             IR_en,
    output logic             IR_vld,
    output logic [RES_W-1:0] IR_dat
);

    localparam int PW = $clog2(PERIOD);
    localparam int SW = $clog2(SETTLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONV,
        ST_WAIT,
        ST_COMMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    per_cnt;
    logic [SW-1:0]    set_cnt;
    logic [2:0]       idx;
    logic             pend;
    logic [RES_W-1:0] back  [8];
    logic [RES_W-1:0] front [8];
    logic [RES_W-1:0] res_val;

    logic per_expire;
    logic leave_idle;
    logic settle_done;
    logic cnv_take;

`ifdef IR_INV_EN
    assign res_val = ~res;
`else
    assign res_val = res;
`endif

    assign per_expire  = (per_cnt == PW'(PERIOD - 1));
    assign settle_done = (state == ST_SETTLE) && (set_cnt == SW'(SETTLE - 1));
    assign cnv_take    = (state == ST_WAIT) && cnv_cmplt;

    always_comb begin
        state_nxt  = state;
        leave_idle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend) begin
                    leave_idle = 1'b1;
                    state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: if (settle_done) state_nxt = ST_CONV;
            ST_CONV:   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cnv_cmplt) state_nxt = (idx == 3'd7) ? ST_COMMIT : ST_CONV;
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Emitters turn on in the IDLE cycle that sees pend, giving SETTLE+1 clocks before the first strobe.
    assign IR_en    = ((state == ST_IDLE) && pend) || (state == ST_SETTLE) ||
                      (state == ST_CONV) || (state == ST_WAIT);
    assign strt_cnv = (state == ST_CONV);
    assign chnnl    = ((state == ST_CONV) || (state == ST_WAIT)) ? idx : 3'd0;
    assign IR_vld   = (state == ST_COMMIT);
    assign IR_dat   = front[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            per_cnt <= '0;
            set_cnt <= '0;
            idx     <= '0;
            pend    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                back[i]  <= '0;
                front[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            per_cnt <= per_expire ? '0 : per_cnt + 1'b1;

            // A fresh expiry wins over the consume so it is never lost.
            if (per_expire)
                pend <= 1'b1;
            else if (leave_idle)
                pend <= 1'b0;

            if (leave_idle)
                set_cnt <= '0;
            else if (state == ST_SETTLE)
                set_cnt <= set_cnt + 1'b1;

            if (settle_done)
                idx <= '0;
            else if (cnv_take)
                idx <= idx + 3'd1;

            // Front loads on the edge into COMMIT so IR_dat already holds the new frame while IR_vld is high.
            if (cnv_take) begin
                back[idx] <= res_val;
                if (idx == 3'd7) begin
                    for (int i = 0; i < 7; i++) front[i] <= back[i];
                    front[7] <= res_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_sample_seq.sv
// Bench for ir_sample_seq: A2D responder feeds a scoreboard queue, scenario tasks check timing and banks.
`timescale 1ns/1ps
module tb_ir_sample_seq;

    localparam int PERIOD = 64;
    localparam int SETTLE = 8;
    localparam int RES_W  = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cnv_cmplt = 1'b0;
    logic [RES_W-1:0] res = '0;
    logic [2:0]       sel = '0;
    logic             strt_cnv;
    logic [2:0]       chnnl;
    logic             IR_en;
    logic             IR_vld;
    logic [RES_W-1:0] IR_dat;

    ir_sample_seq #(.PERIOD(PERIOD), .SETTLE(SETTLE), .RES_W(RES_W)) dut (
        .clk(clk), .rst_n(rst_n), .cnv_cmplt(cnv_cmplt), .res(res), .sel(sel),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .IR_en(IR_en), .IR_vld(IR_vld), .IR_dat(IR_dat)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int a2d_lat = 3;
    int a2d_base = 100;
    int spur_cnt = 0;

    logic [RES_W-1:0] exp_q[$];
    logic [2:0]       ch_log[$];
    logic [RES_W-1:0] front_m[8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cur();
        return cyc - rel_cyc;
    endfunction

    function automatic logic [RES_W-1:0] model_val(input logic [RES_W-1:0] r);
`ifdef IR_INV_EN
        return RES_W'((2 ** RES_W - 1) - int'(r));
`else
        return r;
`endif
    endfunction

    // A2D model: answers each strobe after a2d_lat clocks with res = base + channel
    initial begin : a2d
        int cd;
        bit busy;
        int spur_seen;
        logic [2:0] ch;
        cd = 0; busy = 0; spur_seen = 0; ch = '0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else begin
                if (spur_cnt != spur_seen) begin
                    spur_seen = spur_seen + 1;
                    cnv_cmplt = 1'b1;
                    res = 12'hABC;
                end else if (busy) begin
                    if (cd <= 1) begin
                        busy = 0;
                        cnv_cmplt = 1'b1;
                        res = RES_W'(a2d_base + int'(ch));
                        exp_q.push_back(model_val(res));
                    end else begin
                        cd = cd - 1;
                    end
                end
                if (strt_cnv) begin
                    busy = 1;
                    cd = a2d_lat;
                    ch = chnnl;
                    ch_log.push_back(chnnl);
                end
            end
        end
    end

    // kind 0: IR_en high, 1: strt_cnv (on channel ch, or any if ch<0), 2: IR_vld high
    task automatic wait_cond(input int kind, input int ch, input int budget, output bit ok);
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            case (kind)
                0: if (IR_en) ok = 1;
                1: if (strt_cnv && (ch < 0 || int'(chnnl) == ch)) ok = 1;
                default: if (IR_vld) ok = 1;
            endcase
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (IR_en !== 1'b0) begin failures++; $display("FAIL reset_ir_en got=%b exp=0", IR_en); end
        checks++; if (strt_cnv !== 1'b0) begin failures++; $display("FAIL reset_strt got=%b exp=0", strt_cnv); end
        checks++; if (IR_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", IR_vld); end
        checks++; if (chnnl !== 3'd0) begin failures++; $display("FAIL reset_chnnl got=%0d exp=0", chnnl); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            front_m[i] = '0;
            checks++; if (IR_dat !== '0) begin failures++; $display("FAIL reset_dat sel=%0d got=%h exp=0", i, IR_dat); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_first_frame();
        bit ok;
        bit order_ok;
        logic [RES_W-1:0] e;
        a2d_base = 100; a2d_lat = 3;
        ch_log.delete();
        wait_cond(0, -1, 200, ok);
        checks++; if (!ok || cur() != 64) begin failures++; $display("FAIL first_ir_en_cycle got=%0d exp=64", cur()); end
        wait_cond(1, -1, 50, ok);
        checks++; if (!ok || cur() != 73) begin failures++; $display("FAIL first_strt_cycle got=%0d exp=73", cur()); end
        checks++; if (chnnl !== 3'd0) begin failures++; $display("FAIL first_strt_chnnl got=%0d exp=0", chnnl); end
        wait_cond(2, -1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL first_vld_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL first_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
        order_ok = (ch_log.size() == 8);
        for (int i = 0; i < ch_log.size() && i < 8; i++) if (int'(ch_log[i]) != i) order_ok = 0;
        checks++; if (!order_ok) begin failures++; $display("FAIL first_chnnl_order got_n=%0d exp_n=8", ch_log.size()); end
        @(negedge clk); #1;
        checks++; if (IR_vld !== 1'b0) begin failures++; $display("FAIL first_vld_single got=%b exp=0", IR_vld); end
    endtask

    task automatic test_bank_isolation();
        bit ok;
        logic [RES_W-1:0] e;
        a2d_base = 500;
        wait_cond(1, 4, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL iso_strt4_timeout got=0 exp=1"); end
        @(negedge clk); #1;
        sel = 3'd4; #1;
        checks++; if (IR_dat !== front_m[4]) begin failures++; $display("FAIL iso_old_dat got=%h exp=%h", IR_dat, front_m[4]); end
        wait_cond(2, -1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL iso_vld_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL iso_new_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
    endtask

    task automatic test_spurious();
        bit ok;
        bit order_ok;
        logic [RES_W-1:0] e;
        a2d_base = 300;
        ch_log.delete();
        spur_cnt++;
        repeat (3) @(negedge clk);
        wait_cond(0, -1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL spur_ir_en_timeout got=0 exp=1"); end
        repeat (2) @(negedge clk);
        spur_cnt++;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            checks++; if (IR_dat !== front_m[i]) begin failures++; $display("FAIL spur_front sel=%0d got=%h exp=%h", i, IR_dat, front_m[i]); end
        end
        wait_cond(1, -1, 50, ok);
        checks++; if (!ok || chnnl !== 3'd0) begin failures++; $display("FAIL spur_first_chnnl got=%0d exp=0", chnnl); end
        wait_cond(2, -1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL spur_vld_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL spur_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
        order_ok = (ch_log.size() == 8);
        for (int i = 0; i < ch_log.size() && i < 8; i++) if (int'(ch_log[i]) != i) order_ok = 0;
        checks++; if (!order_ok) begin failures++; $display("FAIL spur_chnnl_order got_n=%0d exp_n=8", ch_log.size()); end
    endtask

    task automatic test_slow();
        bit ok;
        int start;
        int lows;
        logic [RES_W-1:0] e;
        a2d_lat = 70; a2d_base = 512;
        wait_cond(0, -1, 200, ok);
        start = cur();
        checks++; if (!ok) begin failures++; $display("FAIL slow_ir_en_timeout got=0 exp=1"); end
        wait_cond(2, -1, 1500, ok);
        checks++; if (!ok || (cur() - start) <= PERIOD) begin failures++; $display("FAIL slow_span got=%0d exp_gt=%0d", cur() - start, PERIOD); end
        checks++; if (IR_en !== 1'b0) begin failures++; $display("FAIL slow_commit_ir_en got=%b exp=0", IR_en); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL slow_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
        a2d_base = 600;
        @(negedge clk); #1;
        checks++; if (IR_en !== 1'b1) begin failures++; $display("FAIL slow_restart_ir_en got=%b exp=1", IR_en); end
        lows = 0;
        ok = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk); #1;
            if (IR_vld) begin ok = 1; break; end
            if (!IR_en) lows++;
        end
        checks++; if (!ok || lows != 0) begin failures++; $display("FAIL slow_single_start lows=%0d exp=0 vld=%0d", lows, ok); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL slow2_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
        a2d_lat = 3; a2d_base = 700;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [RES_W-1:0] e;
        wait_cond(1, 5, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_strt5_timeout got=0 exp=1"); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (IR_en !== 1'b0) begin failures++; $display("FAIL rmid_ir_en got=%b exp=0", IR_en); end
        checks++; if (strt_cnv !== 1'b0) begin failures++; $display("FAIL rmid_strt got=%b exp=0", strt_cnv); end
        checks++; if (IR_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld got=%b exp=0", IR_vld); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            front_m[i] = '0;
            checks++; if (IR_dat !== '0) begin failures++; $display("FAIL rmid_dat sel=%0d got=%h exp=0", i, IR_dat); end
        end
        repeat (2) @(negedge clk);
        exp_q.delete();
        ch_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_cond(0, -1, 200, ok);
        checks++; if (!ok || cur() != 64) begin failures++; $display("FAIL rmid_ir_en_cycle got=%0d exp=64", cur()); end
        wait_cond(2, -1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_vld_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL rmid_dat2 sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
    endtask

    task automatic test_inv();
        bit ok;
        logic [RES_W-1:0] e;
        logic [RES_W-1:0] want2;
`ifdef IR_INV_EN
        want2 = 12'hF9B;
`else
        want2 = 12'h064;
`endif
        a2d_base = 98;
        wait_cond(2, -1, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL inv_vld_timeout got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i); #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            front_m[i] = e;
            checks++; if (IR_dat !== e) begin failures++; $display("FAIL inv_dat sel=%0d got=%h exp=%h", i, IR_dat, e); end
        end
        sel = 3'd2; #1;
        checks++; if (IR_dat !== want2) begin failures++; $display("FAIL inv_ch2 got=%h exp=%h", IR_dat, want2); end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        test_reset();
        test_first_frame();
        test_bank_isolation();
        test_spurious();
        test_slow();
        test_reset_mid();
        test_inv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_sample_seq.md
Name: ir_sample_seq

Overview:
Producer side of the IR sensor to error-compute path. The block periodically powers the IR emitters and waits for the sensors to settle. It then converts the 8 IR channels through the A2D interface, using a strobe/complete handshake. It commits the 8 results atomically into a read bank, pulses IR_vld, and serves IR_dat indexed by the consumer's sel.

Parameters:
PERIOD, 4096, clocks between frame starts (minimum 64)
SETTLE, 1024, clocks IR_en is high before the first conversion (minimum 2)
RES_W, 12, A2D result width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cnv_cmplt  in  1  A2D conversion done, 1-clk pulse
res  in  RES_W  A2D result, valid when cnv_cmplt=1
sel  in  3  consumer read index
strt_cnv  out  1  1-clk conversion request to A2D
chnnl  out  3  channel for current conversion
IR_en  out  1  IR emitter enable
IR_vld  out  1  1-clk pulse: new frame committed
IR_dat  out  RES_W  front_bank[sel], combinational

Behaviour:
- Reset: all outputs 0. Front and back banks, period counter, settle counter, channel index, pending flag and state are all cleared. State is IDLE.
- Period counter: free-runs 0..PERIOD-1 in every state, then wraps.
  - At count PERIOD-1 it sets pend.
  - Leaving IDLE for SETTLE clears pend.
- State machine: IDLE, SETTLE, CONV, WAIT, COMMIT.
  - IDLE: when pend=1, set IR_en=1, clear the settle counter, go to SETTLE.
  - SETTLE: when the settle counter reaches SETTLE-1, clear idx, go to CONV.
  - CONV: strt_cnv=1 for exactly this cycle, chnnl=idx, go to WAIT.
  - WAIT: chnnl stays at idx. On cnv_cmplt, back[idx] <= res.
    - If idx==7, go to COMMIT.
    - Otherwise idx <= idx+1, go to CONV.
  - COMMIT: front <= back (all 8 words, same edge), IR_vld=1, IR_en=0, go to IDLE.
- Latency:
  - First strt_cnv is SETTLE+1 clocks after IR_en rises.
  - IR_vld is high the cycle after the 8th cnv_cmplt.
  - IR_dat reflects the new frame starting in the IR_vld cycle.
- Front bank:
  - Stable between commits.
  - The consumer may read it over the following 8+ cycles while back-bank conversions of the next frame proceed.
- Boundary conditions:
  - cnv_cmplt outside WAIT is ignored; no write occurs.
  - A period expiry during an active frame sets pend. The next frame starts the cycle after COMMIT returns to IDLE. Multiple expiries collapse to one pend.
  - idx wraps only by leaving WAIT at 7; channels are converted strictly in order 0..7.
  - res is truncated or zero-extended to RES_W, with no arithmetic.
  - Asynchronous reset mid-frame:
    - Immediately drops IR_en and strt_cnv.
    - Discards the partial back bank.
    - Clears the front bank.
    - No IR_vld is issued.
  - sel is a pure read index with no side effects.

Optional Feature:
IR_INV_EN.
- Defined: each result is stored as (2^RES_W-1) - res, i.e. 4095-res for 12 bits, so that a darker line yields a larger value.
- Undefined: res is stored unmodified.
- Timing, handshake and IR_vld behaviour are identical in both builds.

Test Plan:
- Reset/first frame (PERIOD=64, SETTLE=8, cnv_cmplt 3 clks after each strt_cnv, res=100+chnnl):
  - IR_en rises at cycle 64.
  - First strt_cnv at cycle 73 with chnnl=0.
  - Eight strt_cnv pulses on chnnl 0..7.
  - IR_vld is a single pulse.
  - sel=0..7 then reads 100..107.
- Bank isolation: after frame 1 (values 100..107), run frame 2 with res=500+chnnl. While frame 2 is in WAIT for chnnl 4, sel=4 still reads 104. After frame 2's IR_vld, sel=4 reads 504.
- Slow A2D (cnv_cmplt 70 clks after each strt_cnv, PERIOD=64):
  - A frame spans more than one period.
  - The next frame's IR_en rises 1 clk after COMMIT.
  - Exactly one extra frame starts; there is no double start.
- Spurious cnv_cmplt with res=0xABC during SETTLE and during IDLE: the back and front banks are unchanged and idx is not advanced.
- Reset mid-frame (rst_n low during WAIT on chnnl 5):
  - IR_en=0, strt_cnv=0, IR_vld=0 and IR_dat=0 for all sel.
  - After release, the first IR_en occurs at cycle 64 of the new period.
- IR_INV_EN build with res=0x064 on chnnl 2: sel=2 reads 0xF9B after IR_vld.
